seq_mul_unit: RTL and testbench

//   Iterative signed/unsigned integer multiplier for the RV32M execute stage.

---
 rtl/seq_mul_if.sv | 24 ++
 rtl/seq_mul_unit.sv | 160 ++++++++++++++++
 tb/tb_seq_mul_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/seq_mul_if.sv
// Request/response bundle for the iterative multiplier: operands and opcode
// toward the unit, busy/done/result back to the execute stage.
interface seq_mul_if #(
  parameter int XLEN = 32
) ();
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, rs1, rs2, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, op, rs1, rs2, flush,
    output busy, done, result
  );
endinterface

// File: rtl/seq_mul_unit.sv
// Iterative shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes at start, BPC multiplier bits are
// retired per cycle into a 2*XLEN accumulator, and the sign is reapplied
// on the final cycle before selecting the low or high half.
module seq_mul_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic        clk,
  input  logic        rst,
  seq_mul_if.slave    bus
);

  localparam int N  = XLEN / BPC;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CNT_N   = CW'(N);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r, state_s;
  logic [2*XLEN-1:0] mcand_r, mcand_s;
  logic [XLEN-1:0]   mplier_r, mplier_s;
  logic [2*XLEN-1:0] acc_r, acc_s;
  logic [CW-1:0]     count_r, count_s;
  logic [1:0]        op_r, op_s;
  logic              neg_r, neg_s;
  logic              done_r, done_s;
  logic [XLEN-1:0]   result_r, result_s;

  logic              rs1_signed_s, rs2_signed_s;
  logic [XLEN-1:0]   abs1_s, abs2_s;
  logic [2*XLEN-1:0] pp_s, sum_s, prod_s;

  // Magnitude of an operand; the most-negative value maps to 2^(XLEN-1) unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    logic [XLEN-1:0] m;
    if (is_signed && v[XLEN-1]) begin
      m = ~v + {{(XLEN-1){1'b0}}, 1'b1};
    end else begin
      m = v;
    end
    return m;
  endfunction

  // Shifted multiplicand times one BPC-bit multiplier digit.
  function automatic logic [2*XLEN-1:0] partial(input logic [2*XLEN-1:0] mc,
                                                input logic [BPC-1:0]    digit);
    logic [2*XLEN-1:0] p;
    p = {(2*XLEN){1'b0}};
    for (int j = 0; j < BPC; j++) begin
      if (digit[j]) begin
        p = p + (mc << j);
      end else begin
        p = p;
      end
    end
    return p;
  endfunction

  // Next-state and datapath update; flush in RUN aborts without touching result.
  always_comb begin
    state_s  = state_r;
    mcand_s  = mcand_r;
    mplier_s = mplier_r;
    acc_s    = acc_r;
    count_s  = count_r;
    op_s     = op_r;
    neg_s    = neg_r;
    done_s   = 1'b0;
    result_s = result_r;

    rs1_signed_s = (bus.op == 2'b01) || (bus.op == 2'b10);
    rs2_signed_s = (bus.op == 2'b01);
    abs1_s       = magnitude(bus.rs1, rs1_signed_s);
    abs2_s       = magnitude(bus.rs2, rs2_signed_s);

    pp_s   = partial(mcand_r, mplier_r[BPC-1:0]);
    sum_s  = acc_r + pp_s;
    prod_s = neg_r ? (~sum_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : sum_s;

    case (state_r)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          state_s  = ST_RUN;
          mcand_s  = {{XLEN{1'b0}}, abs1_s};
          mplier_s = abs2_s;
          acc_s    = {(2*XLEN){1'b0}};
          count_s  = CNT_N;
          op_s     = bus.op;
          neg_s    = (rs1_signed_s & bus.rs1[XLEN-1]) ^ (rs2_signed_s & bus.rs2[XLEN-1]);
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          state_s = ST_IDLE;
          count_s = {CW{1'b0}};
        end else begin
          acc_s    = sum_s;
          mcand_s  = mcand_r << BPC;
          mplier_s = mplier_r >> BPC;
          count_s  = count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_s  = ST_IDLE;
            done_s   = 1'b1;
            result_s = (op_r == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_r  <= {(2*XLEN){1'b0}};
      mplier_r <= {XLEN{1'b0}};
      acc_r    <= {(2*XLEN){1'b0}};
      count_r  <= {CW{1'b0}};
      op_r     <= 2'b00;
      neg_r    <= 1'b0;
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else begin
      mcand_r  <= mcand_s;
      mplier_r <= mplier_s;
      acc_r    <= acc_s;
      count_r  <= count_s;
      op_r     <= op_s;
      neg_r    <= neg_s;
      done_r   <= done_s;
      result_r <= result_s;
    end
  end

  assign bus.busy   = (state_r == ST_RUN);
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_seq_mul_unit.sv
// Directed bench for seq_mul_unit: a BPC=1 and a BPC=4 instance share clock
// and reset; a vector table covers the opcodes, hand sequences cover
// start-while-busy, start-in-done-cycle, flush and mid-run reset.
module tb_seq_mul_unit;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  seq_mul_if #(.XLEN(32)) b1 ();
  seq_mul_if #(.XLEN(32)) b4 ();

  seq_mul_unit #(.XLEN(32), .BPC(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  seq_mul_unit #(.XLEN(32), .BPC(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic drive(input bit w4, input logic s, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b, input logic f);
    if (w4) begin
      b4.start = s; b4.op = o; b4.rs1 = a; b4.rs2 = b; b4.flush = f;
    end else begin
      b1.start = s; b1.op = o; b1.rs1 = a; b1.rs2 = b; b1.flush = f;
    end
  endtask

  function automatic logic get_busy(input bit w4);
    return w4 ? b4.busy : b1.busy;
  endfunction

  function automatic logic get_done(input bit w4);
    return w4 ? b4.done : b1.done;
  endfunction

  function automatic logic [31:0] get_result(input bit w4);
    return w4 ? b4.result : b1.result;
  endfunction

  // One full operation: checks busy throughout, latency, no busy/done overlap,
  // result and one-cycle done width.
  task automatic run_op(input bit w4, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input string name);
    int lat;
    bit busy_ok;
    int exp_lat;
    exp_lat = w4 ? 9 : 33;
    lat = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    drive(w4, 1'b1, op, a, b, 1'b0);
    @(negedge clk);
    drive(w4, 1'b0, op, a, b, 1'b0);
    for (int c = 1; c <= 100; c++) begin
      if (get_done(w4)) begin
        lat = c;
        break;
      end
      if (!get_busy(w4)) busy_ok = 1'b0;
      @(negedge clk);
    end
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
    chk({name, "_busy_at_done"}, {31'd0, get_busy(w4)}, 32'd0);
    chk({name, "_result"}, get_result(w4), exp);
    @(negedge clk);
    chk({name, "_done_width"}, {31'd0, get_done(w4)}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int   cnt;
    bit   seen_done;
    logic [31:0] prev;

    n_tests = 0;
    n_fail  = 0;
    clk = 1'b0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);

    vecs[0]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    vecs[3]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[5]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6]  = '{2'b01, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[7]  = '{2'b11, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001};
    vecs[8]  = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};
    vecs[9]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000};
    vecs[10] = '{2'b01, 32'h0000_0000, 32'hFFFF_FFFB, 32'h0000_0000};
    vecs[11] = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000};

    // Reset state
    #1;
    chk("rst_busy1", {31'd0, b1.busy}, 32'd0);
    chk("rst_done1", {31'd0, b1.done}, 32'd0);
    chk("rst_result1", b1.result, 32'd0);
    chk("rst_busy4", {31'd0, b4.busy}, 32'd0);
    chk("rst_result4", b4.result, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Vector table on both builds
    for (int i = 0; i < 12; i++) begin
      run_op(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("v%0d_b1", i));
      run_op(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("v%0d_b4", i));
    end

    // Start while busy is ignored
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 1'b0);
    repeat (5) @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    cnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (b1.done) cnt++;
      @(negedge clk);
    end
    chk("busy_start_dones", 32'(cnt), 32'd1);
    chk("busy_start_result", b1.result, 32'hFFFF_FFEB);
    chk("busy_start_idle", {31'd0, b1.busy}, 32'd0);

    // Start in the done cycle is accepted
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b11, 32'h0000_0003, 32'h0000_0005, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, 32'h0000_0003, 32'h0000_0005, 1'b0);
    for (int c = 0; c < 100; c++) begin
      if (b1.done) break;
      @(negedge clk);
    end
    chk("done_cycle_seen", {31'd0, b1.done}, 32'd1);
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0003, 32'h0000_0005, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0003, 32'h0000_0005, 1'b0);
    chk("done_cycle_busy", {31'd0, b1.busy}, 32'd1);
    chk("done_cycle_done_low", {31'd0, b1.done}, 32'd0);
    for (int c = 0; c < 100; c++) begin
      if (b1.done) break;
      @(negedge clk);
    end
    chk("done_cycle_result", b1.result, 32'h0000_000F);

    // Flush 10 cycles into RUN
    prev = b1.result;
    @(negedge clk);
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0009, 32'h0000_0009, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0009, 32'h0000_0009, 1'b0);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", {31'd0, b1.busy}, 32'd1);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0009, 32'h0000_0009, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0009, 32'h0000_0009, 1'b0);
    chk("flush_busy_after", {31'd0, b1.busy}, 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b1.done) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("flush_no_done", {31'd0, seen_done}, 32'd0);
    chk("flush_result_kept", b1.result, prev);
    run_op(1'b0, 2'b00, 32'h0000_0009, 32'h0000_0009, 32'h0000_0051, "after_flush");

    // Start and flush together: request dropped; flush in IDLE is harmless
    drive(1'b0, 1'b1, 2'b00, 32'h0000_0002, 32'h0000_0002, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 32'h0000_0002, 32'h0000_0002, 1'b0);
    chk("start_flush_busy", {31'd0, b1.busy}, 32'd0);
    chk("idle_flush_result", b1.result, 32'h0000_0051);

    // Reset pulsed mid-RUN between edges
    drive(1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, b1.busy}, 32'd0);
    chk("midrst_done", {31'd0, b1.done}, 32'd0);
    chk("midrst_result", b1.result, 32'd0);
    #1;
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (b1.done) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);
    run_op(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "bpc4_mulhu");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
